// File: rtl/lif_tmux_neuron.sv
// Leaky integrate-and-fire neuron: N_IN synapses time-multiplexed onto one multiplier,
// saturating accumulation, runtime leak shift and a refractory period after each spike.
module lif_tmux_neuron #(
    parameter int DATA_W    = 8,
    parameter int STATE_W   = 16,
    parameter int N_IN      = 4,
    parameter int REFRACT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [N_IN*DATA_W-1:0]   currents_i,
    input  logic [N_IN*DATA_W-1:0]   weights_i,
    input  logic [STATE_W-1:0]       bias_i,
    input  logic [STATE_W-1:0]       threshold_i,
    input  logic [3:0]               leak_shift_i,
    input  logic [REFRACT_W-1:0]     refract_cycles_i,
    output logic [STATE_W-1:0]       state_o,
    output logic                     spike_o,
    output logic                     out_valid_o
);

    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int WIDE_W = ((STATE_W > PROD_W) ? STATE_W : PROD_W) + 1;
    localparam logic [STATE_W-1:0] SAT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} fsm_e;

    fsm_e                   fsm_q, fsm_d;
    logic [STATE_W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [STATE_W-1:0]     state_q, state_d;
    logic                   spike_q, spike_d;
    logic                   out_valid_q, out_valid_d;
    logic [REFRACT_W-1:0]   refr_q, refr_d;

    logic [N_IN*DATA_W-1:0] cur_q, wt_q;
    logic [STATE_W-1:0]     thr_q;
    logic [REFRACT_W-1:0]   rc_q;

    logic                   accept;
    logic [DATA_W-1:0]      cur_sel, wt_sel;
    logic [PROD_W-1:0]      prod;
    logic [WIDE_W-1:0]      prod_wide;
    logic [STATE_W-1:0]     prod_sat;
    logic [STATE_W-1:0]     leak_term;
    logic [STATE_W:0]       leak_sum, acc_sum;

    function automatic logic [STATE_W-1:0] sat_carry(input logic [STATE_W:0] v);
        return v[STATE_W] ? SAT_MAX : v[STATE_W-1:0];
    endfunction

    assign accept    = in_valid_i && (fsm_q == IDLE);
    assign cur_sel   = cur_q[idx_q*DATA_W +: DATA_W];
    assign wt_sel    = wt_q[idx_q*DATA_W +: DATA_W];
    assign prod      = cur_sel * wt_sel;
    assign prod_wide = WIDE_W'(prod);
    assign prod_sat  = (prod_wide > WIDE_W'(SAT_MAX)) ? SAT_MAX : prod_wide[STATE_W-1:0];
    // A shift amount at or beyond STATE_W naturally yields a zero leak term.
    assign leak_term = state_q >> leak_shift_i;
    assign leak_sum  = {1'b0, leak_term} + {1'b0, bias_i};
    assign acc_sum   = {1'b0, acc_q} + {1'b0, prod_sat};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        fsm_d       = fsm_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        state_d     = state_q;
        refr_d      = refr_q;
        spike_d     = 1'b0;
        out_valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    acc_d = sat_carry(leak_sum);
                    idx_d = '0;
                    fsm_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = sat_carry(acc_sum);
                if (idx_q == IDX_W'(N_IN - 1)) begin
                    idx_d = '0;
                    fsm_d = FIRE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FIRE: begin
                out_valid_d = 1'b1;
                fsm_d       = IDLE;
                if (refr_q != '0) begin
                    state_d = '0;
                    refr_d  = refr_q - 1'b1;
                end else if (acc_q >= thr_q) begin
                    state_d = '0;
                    spike_d = 1'b1;
                    refr_d  = rc_q;
                end else begin
                    state_d = acc_q;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            state_q     <= '0;
            spike_q     <= 1'b0;
            out_valid_q <= 1'b0;
            refr_q      <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values together.
            fsm_q       <= fsm_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            spike_q     <= spike_d;
            out_valid_q <= out_valid_d;
            refr_q      <= refr_d;
        end
    end

    // NOTE: operand copies carry no reset; they are always written at the handshake before use.
    // Bias and leak shift are consumed in the handshake cycle itself, so they need no copy.
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_q <= currents_i;
            wt_q  <= weights_i;
            thr_q <= threshold_i;
            rc_q  <= refract_cycles_i;
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign state_o     = state_q;
    assign spike_o     = spike_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_lif_tmux_neuron.sv
// Scoreboard bench for lif_tmux_neuron: a behavioural model pushes expected results at each
// handshake and a negedge monitor pops them when out_valid fires.
module tb_lif_tmux_neuron;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] currents = '0;
    logic [31:0] weights = '0;
    logic [15:0] bias = '0;
    logic [15:0] threshold = '0;
    logic [3:0]  leak_shift = '0;
    logic [3:0]  refract_cycles = '0;
    logic [15:0] dut_state;
    logic        spike;
    logic        out_valid;

    typedef struct packed {
        logic [15:0] st;
        logic        sp;
    } exp_t;

    exp_t        sb[$];
    int unsigned mdl_state = 0;
    int unsigned mdl_refr = 0;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [31:0] C_BASE = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] W_BASE = {8'd10, 8'd10, 8'd10, 8'd10};

    lif_tmux_neuron #(.DATA_W(8), .STATE_W(16), .N_IN(4), .REFRACT_W(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .currents_i       (currents),
        .weights_i        (weights),
        .bias_i           (bias),
        .threshold_i      (threshold),
        .leak_shift_i     (leak_shift),
        .refract_cycles_i (refract_cycles),
        .state_o          (dut_state),
        .spike_o          (spike),
        .out_valid_o      (out_valid)
    );

    always #5 clk = ~clk;

    // Monitor: every completed update must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out_valid: state=%0d spike=%0d with no sample pending",
                         dut_state, spike);
            end else begin
                e = sb.pop_front();
                if ({dut_state, spike} !== {e.st, e.sp}) begin
                    miscompares++;
                    $display("FAIL update_result: got state=%0d spike=%0d, expected state=%0d spike=%0d",
                             dut_state, spike, e.st, e.sp);
                end
            end
        end
    end

    task automatic model_push(input logic [31:0] c, input logic [31:0] w, input logic [15:0] b,
                              input logic [15:0] thr, input logic [3:0] ls, input logic [3:0] rc);
        int unsigned a;
        exp_t e;
        a = (mdl_state >> ls) + int'(b);
        if (a > 65535) a = 65535;
        for (int i = 0; i < 4; i++) begin
            a = a + int'(c[i*8 +: 8]) * int'(w[i*8 +: 8]);
            if (a > 65535) a = 65535;
        end
        if (mdl_refr > 0) begin
            e = '{st: 16'd0, sp: 1'b0};
            mdl_refr--;
            mdl_state = 0;
        end else if (a >= int'(thr)) begin
            e = '{st: 16'd0, sp: 1'b1};
            mdl_state = 0;
            mdl_refr = int'(rc);
        end else begin
            e = '{st: a[15:0], sp: 1'b0};
            mdl_state = a;
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] c, input logic [31:0] w, input logic [15:0] b,
                        input logic [15:0] thr, input logic [3:0] ls, input logic [3:0] rc);
        bit got = 1'b0;
        currents = c; weights = w; bias = b; threshold = thr;
        leak_shift = ls; refract_cycles = rc; in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
        end else begin
            model_push(c, w, b, thr, ls, rc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        currents = $urandom; weights = $urandom; threshold = 16'($urandom);
        refract_cycles = 4'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk); k++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0;
        sb.delete(); mdl_state = 0; mdl_refr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({dut_state, spike, out_valid, in_ready} !== {16'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values: state=%0d spike=%0b out_valid=%0b in_ready=%0b, required 0/0/0/1",
                     dut_state, spike, out_valid, in_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        test_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({dut_state, spike, out_valid, in_ready} !== {16'd0, 1'b0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL idle_hold: cycle %0d state=%0d spike=%0b out_valid=%0b in_ready=%0b, required 0/0/0/1",
                         k, dut_state, spike, out_valid, in_ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_integrate();
        test_reset();
        send(C_BASE, W_BASE, 16'd5, 16'd1000, 4'd1, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (k < 6 && {in_ready, out_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL busy_window: T+%0d in_ready=%0b out_valid=%0b, required 0/0", k, in_ready, out_valid);
            end else if (k == 6 && {in_ready, out_valid} !== 2'b11) begin
                miscompares++;
                $display("FAIL done_cycle: T+6 in_ready=%0b out_valid=%0b, required 1/1", in_ready, out_valid);
            end
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL out_valid_pulse: T+7 out_valid=%0b, required 0", out_valid);
        end
        @(posedge clk); #1;
        drain();
        send(C_BASE, W_BASE, 16'd5, 16'd1000, 4'd1, 4'd0);
        drain();
    endtask

    task automatic test_refractory();
        test_reset();
        for (int k = 0; k < 5; k++) send(C_BASE, W_BASE, 16'd5, 16'd150, 4'd1, 4'd2);
        drain();
    endtask

    task automatic test_saturation();
        test_reset();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFF0, 16'hFFFF, 4'd1, 4'd2);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFF0, 16'h0000, 4'd1, 4'd2);
        drain();
        send(C_BASE, W_BASE, 16'd0, 16'd1000, 4'd15, 4'd0);
        send(C_BASE, W_BASE, 16'd0, 16'd0, 4'd3, 4'd0);
        drain();
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int ov_cyc[$];
        test_reset();
        currents = C_BASE; weights = W_BASE; bias = 16'd5; threshold = 16'd1000;
        leak_shift = 4'd1; refract_cycles = 4'd0; in_valid = 1'b1;
        for (int cyc = 0; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc.push_back(cyc);
                model_push(currents, weights, bias, threshold, leak_shift, refract_cycles);
            end
            if (out_valid) ov_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        vectors++;
        if (acc_cyc.size() != 4 || ov_cyc.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_counts: accepts=%0d outputs=%0d, required 4/3", acc_cyc.size(), ov_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (acc_cyc[i] != 6 * i || ov_cyc[i] != 6 * (i + 1)) begin
                    miscompares++;
                    $display("FAIL b2b_timing: #%0d accept@%0d out_valid@%0d, required %0d/%0d",
                             i, acc_cyc[i], ov_cyc[i], 6 * i, 6 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid_accum();
        test_reset();
        send(C_BASE, W_BASE, 16'd5, 16'd150, 4'd1, 4'd2);
        send(C_BASE, W_BASE, 16'd5, 16'd150, 4'd1, 4'd2);
        drain();
        send(C_BASE, W_BASE, 16'd5, 16'd150, 4'd1, 4'd2);
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb.delete(); mdl_state = 0; mdl_refr = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if ({dut_state, in_ready, out_valid} !== {16'd0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_drop: cycle %0d state=%0d in_ready=%0b out_valid=%0b, required 0/1/0",
                         k, dut_state, in_ready, out_valid);
            end
        end
        @(posedge clk); #1;
        send(C_BASE, W_BASE, 16'd5, 16'd150, 4'd1, 4'd2);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_idle();
        test_integrate();
        test_refractory();
        test_saturation();
        test_back_to_back();
        test_reset_mid_accum();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
